alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb.sv | 43 ++++
 rtl/alu.sv | 47 ++++
 tb/tb_alu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and constants for the ALU block.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } op_e;

  // Divide-by-zero result is all ones at any width; replicate this bit.
  localparam logic DIV0_FILL = 1'b1;

endpackage

// File: rtl/alu_comb.sv
// Purely combinational datapath: result for the selected op, plus add carry.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;

  // Carry always tracks A+B, whatever op is selected.
  assign sum   = {1'b0, A} + {1'b0, B};
  assign carry = sum[WIDTH];

  always_comb begin
    result = '0;
    case (op_e'(ALU_Sel))
      OP_ADD:  result = sum[WIDTH-1:0];
      OP_SUB:  result = A - B;
      OP_MUL:  result = A * B;
      OP_DIV:  result = (B == '0) ? {WIDTH{DIV0_FILL}} : A / B;
      OP_SHL:  result = A << 1;
      OP_SHR:  result = A >> 1;
      OP_ROL:  result = {A[WIDTH-2:0], A[WIDTH-1]};
      OP_ROR:  result = {A[0], A[WIDTH-1:1]};
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_NAND: result = ~(A & B);
      OP_XNOR: result = ~(A ^ B);
      OP_GT:   result = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (A == B)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// ALU top: combinational datapath followed by one output register stage.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut
);

  logic [WIDTH-1:0] res;
  logic             cry;
  logic [WIDTH-1:0] alu_out_d, alu_out_q;
  logic             carry_d, carry_q;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .A       (A),
    .B       (B),
    .ALU_Sel (ALU_Sel),
    .result  (res),
    .carry   (cry)
  );

  always_comb begin
    alu_out_d = res;
    carry_d   = cry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      carry_q   <= carry_d;
    end
  end

  assign ALU_Out  = alu_out_q;
  assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed sweeps plus random ops against an arithmetic model.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] A, B;
  logic [3:0] ALU_Sel;
  logic [7:0] ALU_Out;
  logic       CarryOut;

  int n_pass;
  int n_total;

  alu #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: integer arithmetic straight from the op definitions.
  function automatic int ref_result(input int a, input int b, input int sel);
    case (sel)
      0:  return (a + b) % 256;
      1:  return (a - b + 256) % 256;
      2:  return (a * b) % 256;
      3:  return (b == 0) ? 255 : a / b;
      4:  return (a * 2) % 256;
      5:  return a / 2;
      6:  return (a * 2) % 256 + a / 128;
      7:  return a / 2 + (a % 2) * 128;
      8:  return a & b;
      9:  return a | b;
      10: return a ^ b;
      11: return 255 - (a | b);
      12: return 255 - (a & b);
      13: return 255 - (a ^ b);
      14: return (a > b) ? 1 : 0;
      default: return (a == b) ? 1 : 0;
    endcase
  endfunction

  function automatic logic ref_carry(input int a, input int b);
    return (a + b) >= 256;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; A = 8'h33; B = 8'hEE; ALU_Sel = 4'h0;
    #2;
    n_total++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0)
      $display("FAIL reset_state: out=%h carry=%b expected out=00 carry=0", ALU_Out, CarryOut);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0)
      $display("FAIL reset_hold_edge: out=%h carry=%b expected out=00 carry=0", ALU_Out, CarryOut);
    else n_pass++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'h21 || CarryOut !== 1'b1)
      $display("FAIL reset_release_first: out=%h carry=%b expected out=21 carry=1", ALU_Out, CarryOut);
    else n_pass++;
  endtask

  task automatic test_arith_sweep();
    logic [7:0] exp_out [8] = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05};
    A = 8'h0A; B = 8'h02;
    for (int i = 0; i < 8; i++) begin
      ALU_Sel = 4'(i);
      @(posedge clk); #1;
      n_total++;
      if (ALU_Out !== exp_out[i] || CarryOut !== 1'b0)
        $display("FAIL arith_sweep sel=%0h: out=%h carry=%b expected out=%h carry=0",
                 i, ALU_Out, CarryOut, exp_out[i]);
      else n_pass++;
    end
  endtask

  task automatic test_logic_sweep();
    logic [7:0] exp_out [8] = '{8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    A = 8'h0A; B = 8'h02;
    for (int i = 0; i < 8; i++) begin
      ALU_Sel = 4'(i + 8);
      @(posedge clk); #1;
      n_total++;
      if (ALU_Out !== exp_out[i])
        $display("FAIL logic_sweep sel=%0h: out=%h expected %h", i + 8, ALU_Out, exp_out[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    A = 8'hF6; B = 8'h0A; ALU_Sel = 4'h0;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b1)
      $display("FAIL overflow_add: out=%h carry=%b expected out=00 carry=1", ALU_Out, CarryOut);
    else n_pass++;
    ALU_Sel = 4'h1;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'hEC || CarryOut !== 1'b1)
      $display("FAIL overflow_sub: out=%h carry=%b expected out=EC carry=1", ALU_Out, CarryOut);
    else n_pass++;
    ALU_Sel = 4'h2;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'h9C)
      $display("FAIL overflow_mul: out=%h expected 9C", ALU_Out);
    else n_pass++;
  endtask

  task automatic test_rotates();
    A = 8'hF6; B = 8'h00; ALU_Sel = 4'h6;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'hED) $display("FAIL rotate_left: out=%h expected ED", ALU_Out);
    else n_pass++;
    ALU_Sel = 4'h7;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'h7B) $display("FAIL rotate_right: out=%h expected 7B", ALU_Out);
    else n_pass++;
  endtask

  task automatic test_div_eq();
    A = 8'h0A; B = 8'h00; ALU_Sel = 4'h3;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'hFF) $display("FAIL div_by_zero: out=%h expected FF", ALU_Out);
    else n_pass++;
    A = 8'h5A; B = 8'h5A; ALU_Sel = 4'hF;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'h01) $display("FAIL equal: out=%h expected 01", ALU_Out);
    else n_pass++;
  endtask

  // Inputs wiggling between edges must not reach the registered outputs.
  task automatic test_hold();
    A = 8'h80; B = 8'h80; ALU_Sel = 4'h0;
    @(posedge clk); #1;
    A = 8'h01; B = 8'h01; ALU_Sel = 4'h9;
    #3;
    n_total++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b1)
      $display("FAIL hold_between_edges: out=%h carry=%b expected out=00 carry=1", ALU_Out, CarryOut);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'h01 || CarryOut !== 1'b0)
      $display("FAIL hold_next_edge: out=%h carry=%b expected out=01 carry=0", ALU_Out, CarryOut);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    A = 8'hC0; B = 8'h50; ALU_Sel = 4'h9;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'hD0 || CarryOut !== 1'b1)
      $display("FAIL pre_reset_op: out=%h carry=%b expected out=D0 carry=1", ALU_Out, CarryOut);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (ALU_Out !== 8'h00 || CarryOut !== 1'b0)
      $display("FAIL mid_reset_async: out=%h carry=%b expected out=00 carry=0", ALU_Out, CarryOut);
    else n_pass++;
    @(posedge clk); #1;
    A = 8'h07; B = 8'h03; ALU_Sel = 4'h2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (ALU_Out !== 8'h15 || CarryOut !== 1'b0)
      $display("FAIL post_reset_op: out=%h carry=%b expected out=15 carry=0", ALU_Out, CarryOut);
    else n_pass++;
  endtask

  task automatic test_random();
    int a, b, sel, exp_r;
    logic exp_c;
    for (int i = 0; i < 300; i++) begin
      a   = int'($urandom_range(0, 255));
      b   = int'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) b = 0;
      if ($urandom_range(0, 7) == 0) b = a;
      A = 8'(a); B = 8'(b); ALU_Sel = 4'(sel);
      exp_r = ref_result(a, b, sel);
      exp_c = ref_carry(a, b);
      @(posedge clk); #1;
      n_total++;
      if (ALU_Out !== 8'(exp_r) || CarryOut !== exp_c)
        $display("FAIL random a=%h b=%h sel=%h: out=%h carry=%b expected out=%h carry=%b",
                 A, B, ALU_Sel, ALU_Out, CarryOut, 8'(exp_r), exp_c);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_arith_sweep();
    test_logic_sweep();
    test_overflow();
    test_rotates();
    test_div_eq();
    test_hold();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
